// File: rtl/ii_box_sum.sv
// Integral-image box-sum engine.
// A raster-ordered ROW_SIZE x ROW_SIZE frame is loaded and its integral image
// is built on the fly. Square windows are then queried with a 2-stage pipeline
// that combines four integral-image corners into the box sum.
//
//   state | meaning
//   LOAD  | accepting samples, building integral image; queries refused
//   QUERY | frame complete; one box-sum query accepted per cycle
module ii_box_sum #(
  parameter int W        = 8,
  parameter int ROW_SIZE = 4,
  parameter int W_SUM    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 new_sample,
  output logic                         frame_done,
  input  logic                         new_frame,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [$clog2(ROW_SIZE)-1:0]  q_x,
  input  logic [$clog2(ROW_SIZE)-1:0]  q_y,
  input  logic [$clog2(ROW_SIZE):0]    q_win,
  output logic                         r_valid,
  output logic [W_SUM-1:0]             r_sum,
  output logic                         r_err
);

  localparam int CW = $clog2(ROW_SIZE);

  typedef enum logic {LOAD, QUERY} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic [W_SUM-1:0] rowacc;
  logic [W_SUM-1:0] ii [ROW_SIZE][ROW_SIZE];

  logic             load_acc;
  logic             col_last;
  logic             row_last;
  logic [W_SUM-1:0] row_sum;
  logic [W_SUM-1:0] above;
  logic [W_SUM-1:0] ii_new;

  // Sample acceptance; a new_frame in the same cycle discards the sample.
  assign load_acc = in_valid && in_ready && !new_frame;
  assign col_last = (col == CW'(ROW_SIZE - 1));
  assign row_last = (row == CW'(ROW_SIZE - 1));

  // Running row sum plus the integral value directly above the current pixel.
  always_comb begin
    row_sum = rowacc + W_SUM'(new_sample);
    above   = '0;
    if (row != '0) begin
      above = ii[row - CW'(1)][col];
    end
    ii_new = row_sum + above;
  end

  // Integral-image storage; contents survive reset and are overwritten on reload.
  always_ff @(posedge clock) begin
    if (load_acc) begin
      ii[row][col] <= ii_new;
    end
  end

  // Sequencing FSM: raster counters, row accumulator and handshake flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      in_ready   <= 1'b1;
      q_ready    <= 1'b0;
      col        <= '0;
      row        <= '0;
      rowacc     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (new_frame) begin
            col    <= '0;
            row    <= '0;
            rowacc <= '0;
          end else if (in_valid) begin
            if (col_last) begin
              col    <= '0;
              rowacc <= '0;
              if (row_last) begin
                row        <= '0;
                frame_done <= 1'b1;
                state      <= QUERY;
                in_ready   <= 1'b0;
                q_ready    <= 1'b1;
              end else begin
                row <= row + CW'(1);
              end
            end else begin
              col    <= col + CW'(1);
              rowacc <= row_sum;
            end
          end
        end
        QUERY: begin
          if (new_frame) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            q_ready  <= 1'b0;
          end
        end
        default: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          q_ready  <= 1'b0;
        end
      endcase
    end
  end

  logic            q_acc;
  logic [CW+1:0]   x_end;
  logic [CW+1:0]   y_end;
  logic            q_err;
  logic [CW-1:0]   xe;
  logic [CW-1:0]   ye;
  logic [CW-1:0]   xm;
  logic [CW-1:0]   ym;
  logic [W_SUM-1:0] d_val;
  logic [W_SUM-1:0] a_val;
  logic [W_SUM-1:0] b_val;
  logic [W_SUM-1:0] c_val;

  assign q_acc = q_valid && q_ready;

  // Bounds check and corner lookup; indices are forced to 0 whenever they
  // would not be used so no read ever leaves the array.
  always_comb begin
    x_end = {2'b00, q_x} + {1'b0, q_win};
    y_end = {2'b00, q_y} + {1'b0, q_win};
    q_err = (q_win == '0) || (x_end > (CW+2)'(ROW_SIZE)) || (y_end > (CW+2)'(ROW_SIZE));
    xe    = '0;
    ye    = '0;
    xm    = '0;
    ym    = '0;
    if (!q_err) begin
      xe = q_x + q_win[CW-1:0] - CW'(1);
      ye = q_y + q_win[CW-1:0] - CW'(1);
      if (q_x != '0) xm = q_x - CW'(1);
      if (q_y != '0) ym = q_y - CW'(1);
    end
    d_val = '0;
    a_val = '0;
    b_val = '0;
    c_val = '0;
    if (!q_err) begin
      d_val = ii[ye][xe];
      if (q_x != '0 && q_y != '0) a_val = ii[ym][xm];
      if (q_y != '0)              b_val = ii[ym][xe];
      if (q_x != '0)              c_val = ii[ye][xm];
    end
  end

  logic             s1_valid;
  logic             s1_err;
  logic [W_SUM-1:0] s1_d;
  logic [W_SUM-1:0] s1_a;
  logic [W_SUM-1:0] s1_b;
  logic [W_SUM-1:0] s1_c;

  // Two-stage query pipeline: corners first, then the combined result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_d     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_sum    <= '0;
    end else begin
      s1_valid <= q_acc;
      s1_err   <= q_err;
      s1_d     <= d_val;
      s1_a     <= a_val;
      s1_b     <= b_val;
      s1_c     <= c_val;
      r_valid  <= s1_valid;
      r_err    <= s1_valid && s1_err;
      r_sum    <= (s1_valid && !s1_err) ? (s1_d + s1_a - s1_b - s1_c) : '0;
    end
  end

endmodule
